// File: rtl/hazard_forward_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_forward_ctrl
//
// Hazard-detection and forwarding controller for the pipelined MIPS core.
// It records the destination register of every in-flight instruction across
// DEPTH pipeline latches after ID. From that record it decides whether the
// instruction in ID must stall, and where each of its operands comes from.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active low; takes priority over freeze
//   freeze       global pipeline hold: tracking, EX selects and counter hold
//   id_valid     ID holds a real instruction
//   id_flush     ID instruction is squashed this cycle
//   id_rs/id_rt  source registers of the ID instruction
//   id_use_rs/rt ID instruction actually reads rs / rt
//   id_rd        destination register of the ID instruction
//   id_wr        ID instruction writes the register file
//   id_load      ID instruction is a load
//   id_branch    ID instruction compares its operands in ID
//   stall        hold PC and IF/ID, insert a bubble into ID/EX (combinational)
//   fwd_id_a/b   ID compare operand select: 0 = regfile, p = latch p (comb.)
//   fwd_ex_a/b   EX operand select for the instruction now in EX (registered)
//   stall_cnt    saturating count of stall cycles
// ---------------------------------------------------------------------------
module hazard_forward_ctrl #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              id_valid,
    input  logic              id_flush,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              id_branch,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_id_a,
    output logic [SEL_W-1:0]  fwd_id_b,
    output logic [SEL_W-1:0]  fwd_ex_a,
    output logic [SEL_W-1:0]  fwd_ex_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Position arithmetic must hold DEPTH+1 (the position a producer reaches
    // one cycle after leaving the last tracked latch).
    localparam int PW = $clog2(DEPTH + 2);

    // First latch position at which a result can be forwarded.
    localparam logic [PW-1:0] AVAIL_ALU  = PW'(2);
    localparam logic [PW-1:0] AVAIL_LOAD = PW'(2 + LOAD_LAT);

    // ------------------------------------------------------------------
    // Tracking entries, position 1 (ID/EX) .. DEPTH (last latch)
    // ------------------------------------------------------------------
    logic [DEPTH:1]    ent_valid_q, ent_valid_d;
    logic [DEPTH:1]    ent_wr_q,    ent_wr_d;
    logic [REG_AW-1:0] ent_rd_q    [1:DEPTH];
    logic [REG_AW-1:0] ent_rd_d    [1:DEPTH];
    logic [PW-1:0]     ent_avail_q [1:DEPTH];
    logic [PW-1:0]     ent_avail_d [1:DEPTH];

    logic [SEL_W-1:0]  fwd_ex_a_q, fwd_ex_a_d;
    logic [SEL_W-1:0]  fwd_ex_b_q, fwd_ex_b_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // ------------------------------------------------------------------
    // Per-source resolution: index 0 = rs (operand A), 1 = rt (operand B)
    // ------------------------------------------------------------------
    logic [1:0][REG_AW-1:0] src_reg;
    logic [1:0]             src_use;
    logic [1:0]             ex_haz;
    logic [1:0]             br_haz;
    logic [1:0][SEL_W-1:0]  ex_sel;
    logic [1:0][SEL_W-1:0]  id_sel;

    assign src_reg = {id_rt, id_rs};
    assign src_use = {id_use_rt, id_use_rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic          hit;
            logic [PW-1:0] hit_pos;
            logic [PW-1:0] hit_avail;
            logic [PW-1:0] nxt_pos;
            logic          ex_haz_l;
            logic          br_haz_l;
            logic [SEL_W-1:0] ex_sel_l;
            logic [SEL_W-1:0] id_sel_l;

            // Scan from the oldest latch to the youngest so the last hit
            // written is the youngest producer; older producers are shadowed
            // even if their data would already be available.
            always_comb begin
                hit       = 1'b0;
                hit_pos   = '0;
                hit_avail = '0;
                for (int i = DEPTH; i >= 1; i--) begin
                    if (ent_valid_q[i] && ent_wr_q[i] &&
                        (ent_rd_q[i] == src_reg[gi]) &&
                        (src_reg[gi] != '0) && src_use[gi]) begin
                        hit       = 1'b1;
                        hit_pos   = PW'(i);
                        hit_avail = ent_avail_q[i];
                    end
                end
            end

            // The consumer reaches EX next cycle, when the producer has
            // advanced one latch.
            assign nxt_pos = hit_pos + PW'(1);

            // EX operand: a producer past the last latch has written the
            // regfile, which is write-through, so the regfile path is fine.
            always_comb begin
                ex_haz_l = 1'b0;
                ex_sel_l = '0;
                if (hit && (nxt_pos <= PW'(DEPTH))) begin
                    if (nxt_pos >= hit_avail) begin
                        ex_sel_l = SEL_W'(nxt_pos);
                    end else begin
                        ex_haz_l = 1'b1;
                    end
                end
            end

            // Branch compare operand is consumed in ID this cycle.
            always_comb begin
                br_haz_l = 1'b0;
                id_sel_l = '0;
                if (hit && id_branch) begin
                    if (hit_pos >= hit_avail) begin
                        id_sel_l = SEL_W'(hit_pos);
                    end else begin
                        br_haz_l = 1'b1;
                    end
                end
            end

            assign ex_haz[gi] = ex_haz_l;
            assign br_haz[gi] = br_haz_l;
            assign ex_sel[gi] = ex_sel_l;
            assign id_sel[gi] = id_sel_l;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stall and issue decision
    // ------------------------------------------------------------------
    logic live;
    logic issue;

    // A squashed or empty ID slot never stalls, whatever its operands match.
    assign live  = id_valid & ~id_flush;
    assign stall = live & ((|ex_haz) | (|br_haz));
    assign issue = live & ~stall;

    assign fwd_id_a = id_sel[0];
    assign fwd_id_b = id_sel[1];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ent_valid_d = ent_valid_q;
        ent_wr_d    = ent_wr_q;
        ent_rd_d    = ent_rd_q;
        ent_avail_d = ent_avail_q;
        fwd_ex_a_d  = fwd_ex_a_q;
        fwd_ex_b_d  = fwd_ex_b_q;
        stall_cnt_d = stall_cnt_q;

        if (!freeze) begin
            // Advance every tracked instruction one latch; the oldest
            // falls off the end.
            for (int i = DEPTH; i >= 2; i--) begin
                ent_valid_d[i] = ent_valid_q[i-1];
                ent_wr_d[i]    = ent_wr_q[i-1];
                ent_rd_d[i]    = ent_rd_q[i-1];
                ent_avail_d[i] = ent_avail_q[i-1];
            end

            if (issue) begin
                ent_valid_d[1] = 1'b1;
                ent_wr_d[1]    = id_wr;
                ent_rd_d[1]    = id_rd;
                ent_avail_d[1] = id_load ? AVAIL_LOAD : AVAIL_ALU;
                fwd_ex_a_d     = ex_sel[0];
                fwd_ex_b_d     = ex_sel[1];
            end else begin
                // Bubble: nothing to forward into EX next cycle.
                ent_valid_d[1] = 1'b0;
                ent_wr_d[1]    = 1'b0;
                ent_rd_d[1]    = '0;
                ent_avail_d[1] = AVAIL_ALU;
                fwd_ex_a_d     = '0;
                fwd_ex_b_d     = '0;
            end

            if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_valid_q <= '0;
            ent_wr_q    <= '0;
            for (int i = 1; i <= DEPTH; i++) begin
                ent_rd_q[i]    <= '0;
                ent_avail_q[i] <= '0;
            end
            fwd_ex_a_q  <= '0;
            fwd_ex_b_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            ent_valid_q <= ent_valid_d;
            ent_wr_q    <= ent_wr_d;
            ent_rd_q    <= ent_rd_d;
            ent_avail_q <= ent_avail_d;
            fwd_ex_a_q  <= fwd_ex_a_d;
            fwd_ex_b_q  <= fwd_ex_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_ex_a  = fwd_ex_a_q;
    assign fwd_ex_b  = fwd_ex_b_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for hazard_forward_ctrl. Two instances share one stimulus stream:
//   dut0: DEPTH=3, LOAD_LAT=1, SEL_W=2, CNT_W=16 (default core)
//   dut1: DEPTH=4, LOAD_LAT=2, SEL_W=3, CNT_W=2  (deep pipe, tiny counter)
// A reference model derived from the hazard rules predicts each cycle's
// outputs; predictions are queued and a negedge monitor compares them.
// ---------------------------------------------------------------------------
module tb_hazard_forward_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, freeze, id_valid, id_flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_use_rs, id_use_rt, id_wr, id_load, id_branch;

    logic        stall0, stall1;
    logic [1:0]  fid_a0, fid_b0, fex_a0, fex_b0;
    logic [2:0]  fid_a1, fid_b1, fex_a1, fex_b1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    hazard_forward_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_LAT(1), .SEL_W(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .id_branch(id_branch),
        .stall(stall0), .fwd_id_a(fid_a0), .fwd_id_b(fid_b0),
        .fwd_ex_a(fex_a0), .fwd_ex_b(fex_b0), .stall_cnt(cnt0));

    hazard_forward_ctrl #(.REG_AW(5), .DEPTH(4), .LOAD_LAT(2), .SEL_W(3), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .id_branch(id_branch),
        .stall(stall1), .fwd_id_a(fid_a1), .fwd_id_b(fid_b1),
        .fwd_ex_a(fex_a1), .fwd_ex_b(fex_b1), .stall_cnt(cnt1));

    // ---------------- stimulus and model types ----------------
    typedef struct {
        bit rst; bit freeze; bit valid; bit flush;
        bit use_rs; bit use_rt; bit wr; bit load; bit branch;
        int rs; int rt; int rd;
    } stim_t;

    typedef struct { bit v; bit wr; int rd; int avail; } ent_t;

    typedef struct { int stall; int fid_a; int fid_b; int fex_a; int fex_b; int cnt; } exp_t;

    // Model: pipe[k][p] is the instruction p latches past ID in instance k.
    ent_t pipe [2][1:8];
    int   m_depth  [2] = '{3, 4};
    int   m_lat    [2] = '{1, 2};
    int   m_cntmax [2] = '{65535, 3};
    int   m_fex_a  [2];
    int   m_fex_b  [2];
    int   m_cnt    [2];

    exp_t sb0 [$];
    exp_t sb1 [$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset(int k);
        for (int i = 1; i <= 8; i++) begin
            pipe[k][i].v = 1'b0; pipe[k][i].wr = 1'b0;
            pipe[k][i].rd = 0;   pipe[k][i].avail = 2;
        end
        m_fex_a[k] = 0; m_fex_b[k] = 0; m_cnt[k] = 0;
    endfunction

    // Resolve one source against instance k's in-flight instructions.
    function automatic void resolve(int k, int r, bit u, bit branch,
                                    output bit haz, output int ex, output int id);
        int p = 0;
        for (int i = 1; i <= m_depth[k]; i++)
            if (p == 0 && u && r != 0 && pipe[k][i].v && pipe[k][i].wr && pipe[k][i].rd == r)
                p = i;
        haz = 1'b0; ex = 0; id = 0;
        if (p != 0) begin
            // Consumer is in EX next cycle, producer one latch further on.
            if (p + 1 <= m_depth[k]) begin
                if (p + 1 >= pipe[k][p].avail) ex = p + 1;
                else haz = 1'b1;
            end
            if (branch) begin
                if (p >= pipe[k][p].avail) id = p;
                else haz = 1'b1;
            end
        end
    endfunction

    // One clock cycle: drive, predict, let the edge happen, advance the model.
    task automatic step(input stim_t s, output bit st0);
        bit ha, hb;
        bit st [2];
        int exa [2];
        int exb [2];
        int ida, idb;
        exp_t e;
        rst = s.rst; freeze = s.freeze; id_valid = s.valid; id_flush = s.flush;
        id_rs = 5'(s.rs); id_rt = 5'(s.rt); id_rd = 5'(s.rd);
        id_use_rs = s.use_rs; id_use_rt = s.use_rt; id_wr = s.wr;
        id_load = s.load; id_branch = s.branch;
        for (int k = 0; k < 2; k++) begin
            resolve(k, s.rs, s.use_rs, s.branch, ha, exa[k], ida);
            resolve(k, s.rt, s.use_rt, s.branch, hb, exb[k], idb);
            st[k] = s.valid && !s.flush && (ha || hb);
            e.stall = int'(st[k]); e.fid_a = ida; e.fid_b = idb;
            e.fex_a = m_fex_a[k]; e.fex_b = m_fex_b[k]; e.cnt = m_cnt[k];
            if (k == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!s.rst) begin
                model_reset(k);
            end else if (!s.freeze) begin
                bit issue;
                issue = s.valid && !s.flush && !st[k];
                for (int i = m_depth[k]; i >= 2; i--) pipe[k][i] = pipe[k][i-1];
                pipe[k][1].v     = issue;
                pipe[k][1].wr    = issue && s.wr;
                pipe[k][1].rd    = issue ? s.rd : 0;
                pipe[k][1].avail = s.load ? 2 + m_lat[k] : 2;
                m_fex_a[k] = issue ? exa[k] : 0;
                m_fex_b[k] = issue ? exb[k] : 0;
                if (st[k] && m_cnt[k] < m_cntmax[k]) m_cnt[k]++;
            end
        end
        st0 = st[0];
    endtask

    // Hold an instruction in ID until the default instance accepts it.
    task automatic send(input stim_t s);
        bit st;
        int n = 0;
        do begin
            step(s, st);
            n++;
        end while (st && n < 8);
    endtask

    function automatic stim_t mk(bit wr, bit load, bit branch, int rd, int rs, int rt,
                                 bit urs, bit urt);
        stim_t s;
        s.rst = 1'b1; s.freeze = 1'b0; s.valid = 1'b1; s.flush = 1'b0;
        s.wr = wr; s.load = load; s.branch = branch;
        s.rd = rd; s.rs = rs; s.rt = rt; s.use_rs = urs; s.use_rt = urt;
        return s;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("d0_stall", int'(stall0), e.stall);
            chk("d0_fwd_id_a", int'(fid_a0), e.fid_a);
            chk("d0_fwd_id_b", int'(fid_b0), e.fid_b);
            chk("d0_fwd_ex_a", int'(fex_a0), e.fex_a);
            chk("d0_fwd_ex_b", int'(fex_b0), e.fex_b);
            chk("d0_stall_cnt", int'(cnt0), e.cnt);
        end
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            chk("d1_stall", int'(stall1), e.stall);
            chk("d1_fwd_id_a", int'(fid_a1), e.fid_a);
            chk("d1_fwd_id_b", int'(fid_b1), e.fid_b);
            chk("d1_fwd_ex_a", int'(fex_a1), e.fex_a);
            chk("d1_fwd_ex_b", int'(fex_b1), e.fex_b);
            chk("d1_stall_cnt", int'(cnt1), e.cnt);
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        stim_t nop, s;
        bit st;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        nop.valid = 1'b0;

        rst = 1'b0; freeze = 1'b0; id_valid = 1'b0; id_flush = 1'b0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_wr = 1'b0; id_load = 1'b0; id_branch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset(0);
        model_reset(1);

        // Reset state observed while rst stays low.
        s = nop; s.rst = 1'b0;
        step(s, st);

        // ALU -> ALU forwarding
        send(mk(1, 0, 0, 3, 1, 2, 1, 1));
        send(mk(1, 0, 0, 7, 3, 1, 1, 1));
        repeat (3) send(nop);
        // Load-use on both sources
        send(mk(1, 1, 0, 5, 1, 0, 1, 0));
        send(mk(1, 0, 0, 8, 5, 5, 1, 1));
        repeat (4) send(nop);
        // Branch after ALU
        send(mk(1, 0, 0, 4, 1, 2, 1, 1));
        send(mk(0, 0, 1, 0, 4, 0, 1, 1));
        repeat (4) send(nop);
        // Branch after load
        send(mk(1, 1, 0, 6, 1, 0, 1, 0));
        send(mk(0, 0, 1, 0, 6, 0, 1, 1));
        repeat (4) send(nop);
        // Youngest producer wins
        send(mk(1, 0, 0, 2, 1, 1, 1, 1));
        send(mk(1, 0, 0, 2, 3, 3, 1, 1));
        send(mk(1, 0, 0, 9, 2, 1, 1, 1));
        repeat (4) send(nop);
        // Writes to $0, and a flushed consumer
        send(mk(1, 1, 0, 0, 1, 1, 1, 1));
        send(mk(1, 0, 0, 9, 0, 0, 1, 1));
        send(mk(1, 1, 0, 5, 1, 1, 1, 1));
        s = mk(1, 0, 0, 9, 5, 5, 1, 1); s.flush = 1'b1;
        send(s);
        repeat (4) send(nop);
        // Freeze for three cycles in the middle of a load-use stall
        send(mk(1, 1, 0, 7, 1, 1, 1, 0));
        s = mk(1, 0, 0, 9, 7, 1, 1, 1);
        step(s, st);
        s.freeze = 1'b1;
        repeat (3) step(s, st);
        s.freeze = 1'b0;
        send(s);
        repeat (4) send(nop);
        // Reset in the middle of a stall
        send(mk(1, 1, 0, 5, 1, 1, 1, 0));
        s = mk(1, 0, 0, 9, 5, 1, 1, 1);
        step(s, st);
        s.rst = 1'b0;
        step(s, st);
        s.rst = 1'b1;
        send(s);
        repeat (2) send(nop);

        // Randomised traffic on a small register set so hazards are common.
        for (int n = 0; n < 3000; n++) begin
            s.rst    = ($urandom_range(0, 199) != 0);
            s.freeze = ($urandom_range(0, 9) == 0);
            s.valid  = ($urandom_range(0, 9) != 0);
            s.flush  = ($urandom_range(0, 9) == 0);
            s.rs = $urandom_range(0, 3); s.rt = $urandom_range(0, 3);
            s.rd = $urandom_range(0, 3);
            s.use_rs = $urandom_range(0, 3) != 0; s.use_rt = $urandom_range(0, 1) != 0;
            s.wr = $urandom_range(0, 3) != 0;
            s.load = $urandom_range(0, 2) == 0;
            s.branch = $urandom_range(0, 3) == 0;
            step(s, st);
        end

        repeat (2) @(negedge clk);
        #1;
        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Parametrised hazard-detection and forwarding controller for the pipelined MIPS core.
- Replaces the fixed two-source forwarding logic and the single load-use/branch check with one block.
- Tracks the destination register of every in-flight instruction through DEPTH pipeline latches, with a configurable load latency.
- Issues stall/bubble, ID-stage branch forwarding selects, registered EX-stage forwarding selects and a stall-cycle counter.

Parameters:
- REG_AW, 5: register address width; register 0 never produces a hazard.
- DEPTH, 3: number of tracked latches after ID. Position 1 = ID/EX, 2 = EX/MEM, ..., DEPTH = last latch before regfile write.
- LOAD_LAT, 1: extra latches before load data becomes forwardable (load avail = 2+LOAD_LAT). Legal range 0..DEPTH-2.
- SEL_W, 2: forward select width, must be >= clog2(DEPTH+1).
- CNT_W, 16: stall counter width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-low.
- freeze, in, 1: global pipeline hold (e.g. memory not ready).
- id_valid, in, 1: ID holds a real instruction.
- id_flush, in, 1: ID instruction is squashed this cycle (taken branch/jump).
- id_rs, in, REG_AW: source register A of the ID instruction.
- id_rt, in, REG_AW: source register B of the ID instruction.
- id_use_rs, in, 1: ID instruction reads rs.
- id_use_rt, in, 1: ID instruction reads rt.
- id_rd, in, REG_AW: destination register (rd or rt, already muxed).
- id_wr, in, 1: ID instruction writes the regfile.
- id_load, in, 1: ID instruction is a load.
- id_branch, in, 1: ID instruction compares its operands in ID.
- stall, out, 1: hold PC and IF/ID, zero control into ID/EX.
- fwd_id_a, out, SEL_W: combinational select for ID compare operand A. 0 = regfile, p = latch p.
- fwd_id_b, out, SEL_W: same as fwd_id_a, for operand B.
- fwd_ex_a, out, SEL_W: registered select for the EX operand A of the instruction now in EX.
- fwd_ex_b, out, SEL_W: same as fwd_ex_a, for EX operand B.
- stall_cnt, out, CNT_W: saturating count of stall cycles.

Behaviour:
- Tracking entry per position p: valid, wr, rd, avail. avail = 2 for ALU ops, 2+LOAD_LAT for loads.
- A match at p for source r requires: valid & wr & rd==r & r!=0 & source used.
- Only the youngest (lowest p) match is considered; older matches are ignored even when they are available.
- EX operand check (every used source, evaluated in ID):
  - Next cycle the producer is at q = p+1.
  - q > DEPTH: select 0. The regfile is write-through in the same cycle.
  - q >= avail: next-cycle fwd_ex = q.
  - Otherwise: hazard.
- Branch operand check (id_branch=1):
  - Operand is needed this cycle.
  - p >= avail: fwd_id = p.
  - p < avail: hazard.
  - No match: fwd_id = 0.
  - fwd_id = 0 whenever id_branch=0.
- stall = id_valid & ~id_flush & (any hazard). stall is combinational and is reported even while freeze=1.
- Rising edge, freeze=0:
  - Entries shift p -> p+1; entry DEPTH is discarded.
  - Position 1 loads the ID instruction when id_valid & ~id_flush & ~stall. Otherwise position 1 loads a bubble (valid=0).
  - fwd_ex_a/b load the computed selects. They load 0 on a bubble.
  - stall_cnt increments when stall=1, saturating at all-ones.
- Rising edge, freeze=1: entries, fwd_ex_a/b and stall_cnt all hold.
- Reset (rst=0 at an edge, including mid-operation): all entries invalid, fwd_ex_a/b=0, stall_cnt=0. rst dominates freeze.
- Latency:
  - stall and fwd_id are combinational (0 cycles).
  - fwd_ex is 1 cycle after the ID evaluation.
  - A load-use stall with DEPTH=3, LOAD_LAT=1 lasts exactly 1 cycle.
  - A branch depending on a just-issued load stalls 2 cycles.
- Both sources hazarding: a single stall covers both. Each select is resolved independently.

Test Plan:
- ALU-ALU: add $3 then sub using $3 as rs, no stall. Expect fwd_ex_a=2 on the cycle sub is in EX, stall=0.
- Load-use: lw $5 then add rs=$5, rt=$5. Expect stall=1 for 1 cycle, a bubble, then fwd_ex_a=fwd_ex_b=3, stall_cnt=1.
- Branch after ALU: add $4 then beq $4,$0. Expect stall 1 cycle, then fwd_id_a=2, fwd_id_b=0.
- Branch after load: expect stall 2 cycles, then fwd_id_a=3, stall_cnt=2.
- Youngest wins: add $2, or $2, and using $2. Expect fwd_ex_a=2, not 3.
- $0 and flush: writes to $0 give no hazard. A consumer with id_flush=1 gives stall=0.
- Freeze: freeze=1 for 3 cycles mid-stall. Entries, fwd_ex and stall_cnt hold; stall stays 1.
- Reset: rst=0 mid-operation gives cleared outputs at the next edge.
- Parameters: DEPTH=4, LOAD_LAT=2. Load-use gives stall 2 cycles, then fwd_ex=4.
- Saturation: with CNT_W=2, 5 stall cycles give stall_cnt=3.
